// File: rtl/debounce_pkg.sv
// Shared types, defaults and sizing helper for the debounce/pulser array.
// Optional auto-repeat is enabled by defining AUTO_REPEAT_EN.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } ch_state_t;

  localparam int DEF_CH          = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DB_CYCLES   = 16;
  localparam int DEF_RPT_DELAY   = 64;
  localparam int DEF_RPT_PERIOD  = 16;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_pulser_ch.sv
// One button channel: synchronizer, counter debouncer, press/release FSM and
// registered pulses. Auto-repeat logic is compiled in only with AUTO_REPEAT_EN.
module debounce_pulser_ch
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int RPT_DELAY   = DEF_RPT_DELAY,
  parameter int RPT_PERIOD  = DEF_RPT_PERIOD
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      press_i,
  output logic      level_o,
  output logic      sp_o,
  output logic      rel_o,
  output ch_state_t state_o
);

  localparam int DBW = cnt_width(DB_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  if (SYNC_STAGES < 2 || DB_CYCLES < 1 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_param_check
    $error("debounce_pulser_ch: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DBW-1:0]         db_cnt_q, db_cnt_d;
  logic                   level_q, level_d;
  logic                   sp_q, sp_d;
  logic                   rel_q, rel_d;
  ch_state_t              state_q, state_d;
  logic                   sync, rise, fall;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], press_i};
  assign sync   = sync_q[SYNC_STAGES-1];

  // A level change is accepted only after DB_CYCLES consecutive mismatches.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = db_cnt_q;
    if (sync == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_d  = ~level_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW      = cnt_width(RPT_MAX);
  localparam logic [RW-1:0] RPT_DLY_LAST = RW'(RPT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PER_LAST = RW'(RPT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

  // Pulses are decided from level_d so they align with the level_o edge.
  always_comb begin
    state_d = state_q;
    sp_d    = 1'b0;
    rel_d   = 1'b0;
`ifdef AUTO_REPEAT_EN
    rpt_cnt_d = rpt_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HELD;
          sp_d    = 1'b1;
`ifdef AUTO_REPEAT_EN
          rpt_cnt_d = '0;
`endif
        end
      end
      HELD: begin
        if (fall) begin
          state_d = IDLE;
          rel_d   = 1'b1;
        end
`ifdef AUTO_REPEAT_EN
        else if (rpt_cnt_q == RPT_DLY_LAST) begin
          state_d   = REPEAT;
          sp_d      = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
`endif
      end
      REPEAT: begin
        // Release wins over a repeat pulse due in the same cycle.
        if (fall) begin
          state_d = IDLE;
          rel_d   = 1'b1;
        end
`ifdef AUTO_REPEAT_EN
        else if (rpt_cnt_q == RPT_PER_LAST) begin
          sp_d      = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      sp_q     <= 1'b0;
      rel_q    <= 1'b0;
      state_q  <= IDLE;
    end else begin
      sync_q   <= sync_d;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      sp_q     <= sp_d;
      rel_q    <= rel_d;
      state_q  <= state_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`endif

  assign level_o = level_q;
  assign sp_o    = sp_q;
  assign rel_o   = rel_q;
  assign state_o = state_q;

endmodule

// File: rtl/debounce_pulser_array.sv
// CH independent debounced push-button channels with press/release pulses.
// Define AUTO_REPEAT_EN to add periodic press pulses while a button is held.
module debounce_pulser_array
  import debounce_pkg::*;
#(
  parameter int CH          = DEF_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int RPT_DELAY   = DEF_RPT_DELAY,
  parameter int RPT_PERIOD  = DEF_RPT_PERIOD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic      [CH-1:0]   press_i,
  output logic      [CH-1:0]   level_o,
  output logic      [CH-1:0]   SP_o,
  output logic      [CH-1:0]   rel_o,
  output ch_state_t [CH-1:0]   dbg_state_o
);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    debounce_pulser_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES),
      .RPT_DELAY   (RPT_DELAY),
      .RPT_PERIOD  (RPT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .press_i (press_i[c]),
      .level_o (level_o[c]),
      .sp_o    (SP_o[c]),
      .rel_o   (rel_o[c]),
      .state_o (dbg_state_o[c])
    );
  end

endmodule

// File: tb/tb_debounce_pulser_array.sv
// Self-checking bench for debounce_pulser_array: directed table, corner-case
// sequences and random stimulus against a window-based reference model.
module tb_debounce_pulser_array;
  import debounce_pkg::*;

  localparam int CH  = 4;
  localparam int SS  = 2;
  localparam int DB  = 16;
  localparam int RD  = 64;
  localparam int RP  = 16;
  localparam int HL  = SS + DB;
  localparam int LAT = SS + DB - 1;
  localparam int W   = 3 * CH;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic      [CH-1:0]   press_i = '0;
  logic      [CH-1:0]   level_o, SP_o, rel_o;
  ch_state_t [CH-1:0]   dbg_state_o;

  always #5 clk = ~clk;

  debounce_pulser_array #(
    .CH (CH), .SYNC_STAGES (SS), .DB_CYCLES (DB), .RPT_DELAY (RD), .RPT_PERIOD (RP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .press_i     (press_i),
    .level_o     (level_o),
    .SP_o        (SP_o),
    .rel_o       (rel_o),
    .dbg_state_o (dbg_state_o)
  );

  int checks   = 0;
  int failures = 0;
  int tick_no  = 0;
  int base     = 0;

  logic [W-1:0] exp_q[$];

  // Reference model: raw sample history, newest at index 0.
  logic [CH-1:0] m_hist [HL];
  logic [CH-1:0] m_level;
  int            m_since [CH];
  int            m_due   [CH];

  int            sp_cnt    [CH];
  int            rel_cnt   [CH];
  int            first_sp  [CH];
  int            first_rel [CH];
  logic [CH-1:0] last_sp_val;
  int            sp0_times[$];

  typedef struct {
    logic [CH-1:0] press;
    int            cycles;
    logic [CH-1:0] exp_level;
    int            exp_sp;
    int            exp_rel;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, tick_no);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < HL; i++) m_hist[i] = '0;
    m_level = '0;
    for (int c = 0; c < CH; c++) begin
      m_since[c] = 0;
      m_due[c]   = RD;
    end
  endtask

  // A channel's level flips when the last DB synchronized samples all
  // disagree with it; the synchronizer delays raw samples by SS edges.
  task automatic model_edge();
    logic [CH-1:0] sp, rel, new_level;
    bit            all_diff;
    sp  = '0;
    rel = '0;
    if (!rst) begin
      model_clear();
      exp_q.push_back('0);
      return;
    end
    for (int i = HL - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = press_i;
    new_level = m_level;
    for (int c = 0; c < CH; c++) begin
      all_diff = 1'b1;
      for (int i = 0; i < DB; i++)
        if (m_hist[SS+i][c] == m_level[c]) all_diff = 1'b0;
      if (all_diff) new_level[c] = ~m_level[c];
      if (new_level[c] && !m_level[c]) begin
        sp[c]      = 1'b1;
        m_since[c] = 0;
        m_due[c]   = RD;
      end else if (!new_level[c] && m_level[c]) begin
        rel[c] = 1'b1;
      end
`ifdef AUTO_REPEAT_EN
      else if (new_level[c]) begin
        m_since[c]++;
        if (m_since[c] == m_due[c]) begin
          sp[c]      = 1'b1;
          m_since[c] = 0;
          m_due[c]   = RP;
        end
      end
`endif
    end
    m_level = new_level;
    exp_q.push_back({new_level, sp, rel});
  endtask

  task automatic compare();
    logic [W-1:0] exp, act;
    act = {level_o, SP_o, rel_o};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty at tick %0d", tick_no);
      return;
    end
    exp = exp_q.pop_front();
    if (act !== exp) begin
      failures++;
      $display("FAIL scoreboard tick=%0d got lvl/sp/rel=%h expected %h", tick_no, act, exp);
    end
    checks++;
    if ((SP_o & rel_o) != '0) begin
      failures++;
      $display("FAIL sp_rel_overlap tick=%0d got %b expected 0", tick_no, SP_o & rel_o);
    end
    for (int c = 0; c < CH; c++) begin
      if (SP_o[c] === 1'b1) begin
        sp_cnt[c]++;
        if (first_sp[c] < 0) first_sp[c] = tick_no;
      end
      if (rel_o[c] === 1'b1) begin
        rel_cnt[c]++;
        if (first_rel[c] < 0) first_rel[c] = tick_no;
      end
    end
    if (SP_o != '0) last_sp_val = SP_o;
    if (SP_o[0] === 1'b1) sp0_times.push_back(tick_no);
  endtask

  task automatic tick();
    @(posedge clk);
    tick_no++;
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input logic [CH-1:0] p, input int n);
    press_i = p;
    repeat (n) tick();
  endtask

  task automatic clear_counts();
    for (int c = 0; c < CH; c++) begin
      sp_cnt[c]    = 0;
      rel_cnt[c]   = 0;
      first_sp[c]  = -1;
      first_rel[c] = -1;
    end
    last_sp_val = '0;
    sp0_times.delete();
    base = tick_no;
  endtask

  function automatic int sum_sp();
    int s = 0;
    for (int c = 0; c < CH; c++) s += sp_cnt[c];
    return s;
  endfunction

  function automatic int sum_rel();
    int s = 0;
    for (int c = 0; c < CH; c++) s += rel_cnt[c];
    return s;
  endfunction

  // Called at a negedge: async assert, then check the immediate clear.
  task automatic assert_reset(input logic [CH-1:0] p);
    rst     = 1'b0;
    press_i = p;
    model_clear();
    #1;
    chk("rst_async_clear", int'({level_o, SP_o, rel_o}), 0);
    for (int c = 0; c < CH; c++)
      chk("rst_state_idle", int'(dbg_state_o[c]), int'(IDLE));
  endtask

  initial begin
    model_clear();
    clear_counts();

    vecs[0] = '{4'h1,  5, 4'h0, 0, 0};
    vecs[1] = '{4'h0,  3, 4'h0, 0, 0};
    vecs[2] = '{4'h1,  8, 4'h0, 0, 0};
    vecs[3] = '{4'h0, 30, 4'h0, 0, 0};
    vecs[4] = '{4'h2, 40, 4'h2, 1, 0};
    vecs[5] = '{4'h0, 40, 4'h0, 0, 1};
    vecs[6] = '{4'hC, 30, 4'hC, 2, 0};
    vecs[7] = '{4'h8, 30, 4'h8, 0, 1};
    vecs[8] = '{4'h0, 30, 4'h0, 0, 1};
    vecs[9] = '{4'h5, 15, 4'h0, 0, 0};

    // Reset held with all buttons pressed.
    press_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_outputs_low", int'({level_o, SP_o, rel_o}), 0);
    end
    rst = 1'b1;
    clear_counts();
    run(4'hF, 30);
    for (int c = 0; c < CH; c++) begin
      chk("rst_release_sp_count", sp_cnt[c], 1);
      chk("rst_release_latency", first_sp[c] - (base + 1), LAT);
    end
    clear_counts();
    run(4'h0, 40);
    chk("rst_release_rel_count", sum_rel(), CH);

    // Directed table.
    for (int v = 0; v < NV; v++) begin
      clear_counts();
      run(vecs[v].press, vecs[v].cycles);
      chk($sformatf("vec%0d_level", v), int'(level_o), int'(vecs[v].exp_level));
      chk($sformatf("vec%0d_sp", v), sum_sp(), vecs[v].exp_sp);
      chk($sformatf("vec%0d_rel", v), sum_rel(), vecs[v].exp_rel);
      if (v == 4) chk("clean_press_latency", first_sp[1] - (base + 1), LAT);
      if (v == 5) chk("clean_release_latency", first_rel[1] - (base + 1), LAT);
      if (v == 6) chk("simultaneous_sp_mask", int'(last_sp_val), 4'hC);
    end
    run(4'h0, 30);

    // Reset while ch1 debounce counter is at 10.
    run(4'h2, 12);
    assert_reset(4'h0);
    repeat (3) tick();
    rst = 1'b1;
    clear_counts();
    run(4'h0, 40);
    chk("rst_mid_count_no_sp", sum_sp(), 0);
    chk("rst_mid_count_no_rel", sum_rel(), 0);

    // Reset while ch2 held; button stays down through reset.
    run(4'h4, 30);
    chk("held_level_before_rst", int'(level_o), 4'h4);
    assert_reset(4'h4);
    repeat (3) tick();
    rst = 1'b1;
    clear_counts();
    run(4'h4, 30);
    chk("held_through_rst_sp", sp_cnt[2], 1);
    chk("held_through_rst_latency", first_sp[2] - (base + 1), LAT);
    chk("held_through_rst_no_rel", sum_rel(), 0);
    run(4'h0, 40);

`ifdef AUTO_REPEAT_EN
    // Auto-repeat: hold ch0 for 200 cycles.
    begin
      int t0, exp_n, fall_t;
      clear_counts();
      run(4'h1, 200);
      run(4'h0, 40);
      t0     = base + 1 + LAT;
      fall_t = base + 201 + LAT;
      exp_n  = 1;
      for (int t = t0 + RD; t < fall_t; t += RP) exp_n++;
      chk("repeat_count", sp0_times.size(), exp_n);
      for (int i = 0; i < exp_n && i < sp0_times.size(); i++)
        chk($sformatf("repeat_time%0d", i), sp0_times[i],
            (i == 0) ? t0 : t0 + RD + (i - 1) * RP);
      chk("repeat_rel_count", rel_cnt[0], 1);
      chk("repeat_rel_time", first_rel[0], fall_t);
    end
`endif

    // Random stimulus against the reference model.
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        assert_reset(CH'($urandom));
        repeat ($urandom_range(1, 3)) tick();
        rst = 1'b1;
      end
      run(CH'($urandom), $urandom_range(1, 45));
    end
    run(4'h0, 40);
    chk("final_level_low", int'(level_o), 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debounce_pulser_array.md
# debounce_pulser_array

Parametrised successor to the single-channel pulser. Accepts CH raw asynchronous push-button inputs and passes each through a synchronizer and a counter-based debouncer. Each channel then emits exactly one clock-wide pulse per accepted press and per accepted release. It sits between board-level button pins and any control FSM, replacing the ad-hoc synchronizer/debouncer/single-pulser chain. An optional auto-repeat mode emits periodic press pulses while a button is held.

## Interface
- CH, 4: number of independent channels (>=1)
- SYNC_STAGES, 2: flip-flop stages in each input synchronizer (>=2)
- DB_CYCLES, 16: consecutive stable cycles required to accept a level change (>=1)
- RPT_DELAY, 64: held cycles after a press pulse before the first repeat pulse (used only with AUTO_REPEAT_EN; >=1)
- RPT_PERIOD, 16: cycles between subsequent repeat pulses (used only with AUTO_REPEAT_EN; >=1)
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-low reset; all state clears while rst==0
- press_i  input  CH  raw asynchronous button levels, 1 = pressed
- level_o  output  CH  debounced level per channel
- SP_o  output  CH  one-cycle press pulse per channel; includes repeat pulses when enabled
- rel_o  output  CH  one-cycle release pulse per channel

## Operation
- Reset values: level_o=0, SP_o=0, rel_o=0. Synchronizer stages, debounce counters and repeat counters clear to 0. Every channel FSM enters IDLE.
- Synchronizer: each press_i bit passes through a SYNC_STAGES-deep flop chain. The output of this chain is sync[c].
- Debouncer, per channel: counter db_cnt, width $clog2(DB_CYCLES+1).
  - If sync==level, db_cnt is cleared.
  - Otherwise db_cnt increments.
  - When db_cnt==DB_CYCLES-1 and sync still differs from level, level toggles on that edge and db_cnt clears.
  - Any glitch shorter than DB_CYCLES cycles is discarded, and the counter restarts from 0 on the next mismatch.
- Pulses are registered. SP_o[c]=1 exactly in the first cycle that level_o[c] reads 1. rel_o[c]=1 exactly in the first cycle that level_o[c] reads 0 after having been 1.
- Per-channel FSM:
  - IDLE (level=0): on level rise, go to HELD and pulse SP_o.
  - HELD: on level fall, go to IDLE and pulse rel_o. With AUTO_REPEAT_EN: after RPT_DELAY cycles in HELD, pulse SP_o and go to REPEAT.
  - REPEAT (macro only): pulse SP_o every RPT_PERIOD cycles. On level fall, go to IDLE and pulse rel_o.
- Channels are fully independent. Simultaneous events on different channels all produce their pulses in the same cycle.
- SP_o and rel_o on one channel are never high together. A release always takes priority over a repeat pulse due in the same cycle.
- Reset asserted mid-count or mid-hold clears everything immediately. No pulse is emitted on reset deassertion, even if press_i is held. A button held through reset is accepted as a new press once debounced.

## Timing
- Press latency: press_i is first sampled high at edge k and held stable. level_o and SP_o go high after edge k+SYNC_STAGES+DB_CYCLES-1. With defaults, this is 17 edges.
- Release latency is symmetric.
- SP_o and rel_o are exactly one cycle wide.
- Repeat, with the macro: the first repeat pulse follows the press pulse by RPT_DELAY cycles. Subsequent repeat pulses are spaced by RPT_PERIOD cycles.
- Minimum spacing between accepted edges on one channel is DB_CYCLES cycles.

## Configuration
- AUTO_REPEAT_EN defined:
  - The REPEAT state and the repeat counter are compiled in.
  - The counter width is $clog2(max(RPT_DELAY,RPT_PERIOD)+1).
  - Held buttons generate periodic SP_o pulses.
- AUTO_REPEAT_EN undefined:
  - No repeat logic exists. RPT_DELAY and RPT_PERIOD are ignored.
  - Exactly one SP_o pulse is produced per accepted press.

## Structure
- Shared package debounce_pkg holds:
  - the channel FSM state enum (IDLE, HELD, REPEAT);
  - a width helper function for counter sizing;
  - default parameter constants.
- One sub-module, debounce_pulser_ch, implements one channel: synchronizer, debouncer, FSM and pulse registers. It is instantiated CH times in a generate loop. The top level only fans out the bits.

## Test plan
- Reset: hold rst=0 with press_i=4'hF, then release reset. Required: level_o, SP_o and rel_o all read 0 during reset. SP_o pulses once per channel, 17 edges after the first sample.
- Bounce: on channel 0, toggle press_i[0] high for 5 cycles, low for 3, high for 8, then low. Required: no SP_o[0] and no change in level_o[0].
- Clean press/release: press_i[1]=1 for 40 cycles, then 0. Required: exactly one SP_o[1] at latency 17 and exactly one rel_o[1] 17 cycles after the fall.
- Simultaneous: channels 2 and 3 rise on the same edge. Required: SP_o=4'b1100 in one cycle. Channel 2 releasing mid-hold must not affect channel 3.
- Reset mid-operation: assert rst at db_cnt=10. Required: immediate clear and no pulse at deassert with the input low.
- Auto-repeat, with the macro: hold press_i[0] for 200 cycles. Required: SP_o[0] pulses at press time T, T+64, T+80, T+96 and so on. rel_o[0] fires once after the release, with no repeat pulse in that cycle.
